serial_bus_arbiter: RTL and testbench

- Arbitrates ownership of the shared serial data bus among NUM_MASTERS bus masters.
- Sequences each ownership tenure for the memory/peripheral slaves on the same bus:
  - drives the global bus_util line;
  - issues the arbiter_cmd release pulse at the end of each tenure;
  - waits for every slave's busy_out to drop before re-arbitrating.
- Includes a tenure watchdog and a sticky timeout flag.
- Sits at top level beside the masters and the memory slaves.

---
 rtl/serial_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_serial_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_arbiter.sv
// Serial bus arbiter: round-robin tenure sequencing with drain and watchdog.
// Define SBA_FIXED_PRIORITY_EN for lowest-index-wins selection.
module serial_bus_arbiter #(
   parameter int unsigned NUM_MASTERS = 3,
   parameter int unsigned NUM_SLAVES = 3,
   parameter int unsigned TIMEOUT_WIDTH = 12,
   parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 12'd2000
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [NUM_MASTERS-1:0] m_req,
   input  logic [NUM_SLAVES-1:0]  slv_busy,
   output logic [NUM_MASTERS-1:0] m_grant,
   output logic [2:0]             grant_id,
   output logic                   bus_util,
   output logic                   arbiter_cmd,
   output logic                   timeout_flag,
   output logic [1:0]             state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   localparam logic [TIMEOUT_WIDTH-1:0] ONE =
      {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [TIMEOUT_WIDTH-1:0] CNT_MAX = TIMEOUT_CYCLES - ONE;
   localparam logic [2:0] LAST = 3'(NUM_MASTERS - 1);

   state_t                   state_q, state_d;
   logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
   logic [NUM_MASTERS-1:0]   grant_q, grant_d;
   logic [2:0]               gid_q, gid_d;
   logic                     tflag_q, tflag_d;
   logic                     win_found;
   logic [2:0]               win_idx;
   logic                     owner_req;

`ifndef SBA_FIXED_PRIORITY_EN
   logic [2:0] rr_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_q <= '0;
      end else if (state_q == IDLE && win_found) begin
         rr_q <= (win_idx == LAST) ? 3'd0 : win_idx + 3'd1;
      end
   end
`endif

   // Lowest requester overall, then (round-robin) lowest at or above rr_q.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (m_req[i]) begin
            win_found = 1'b1;
            win_idx   = 3'(i);
         end
      end
`ifndef SBA_FIXED_PRIORITY_EN
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (m_req[i] && 3'(i) >= rr_q) win_idx = 3'(i);
      end
`endif
   end

   assign owner_req = |(m_req & grant_q);
   assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + ONE;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      gid_d   = gid_q;
      tflag_d = tflag_q;
      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = GRANT;
               grant_d = NUM_MASTERS'(1) << win_idx;
               gid_d   = win_idx;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            cnt_d = cnt_inc;
            if (!owner_req) begin
               state_d = RELEASE;
               grant_d = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = RELEASE;
               grant_d = '0;
               tflag_d = 1'b1;
            end
         end
         RELEASE: begin
            state_d = DRAIN;
            cnt_d   = '0;
         end
         DRAIN: begin
            cnt_d = cnt_inc;
            if (slv_busy == '0) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_MAX) begin
               state_d = IDLE;
               tflag_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         grant_q <= '0;
         gid_q   <= '0;
         tflag_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         gid_q   <= gid_d;
         tflag_q <= tflag_d;
      end
   end

   assign m_grant      = grant_q;
   assign grant_id     = gid_q;
   assign bus_util     = (state_q == IDLE);
   assign arbiter_cmd  = (state_q == RELEASE);
   assign timeout_flag = tflag_q;
   assign state        = state_q;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Bench for serial_bus_arbiter: tenure-level reference model plus
// directed scenarios with hand-computed checkpoints.
module tb_serial_bus_arbiter;

   localparam int N = 3;
   localparam int T = 16;

   logic       clk;
   logic       rstn;
   logic [2:0] m_req;
   logic [2:0] slv_busy;
   logic [2:0] m_grant;
   logic [2:0] grant_id;
   logic       bus_util;
   logic       arbiter_cmd;
   logic       timeout_flag;
   logic [1:0] state;

   int nvec  = 0;
   int nfail = 0;

   serial_bus_arbiter #(
      .NUM_MASTERS(3),
      .NUM_SLAVES(3),
      .TIMEOUT_WIDTH(12),
      .TIMEOUT_CYCLES(12'd16)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .m_req(m_req),
      .slv_busy(slv_busy),
      .m_grant(m_grant),
      .grant_id(grant_id),
      .bus_util(bus_util),
      .arbiter_cmd(arbiter_cmd),
      .timeout_flag(timeout_flag),
      .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model. ph: 0 bus free, 1 owned, 2 release pulse, 3 draining.
   // age counts the cycles spent so far in the current owned/drain phase.
   int ph, own, age, base;
   bit tf;

   function automatic int pick(input logic [2:0] req, input int b);
      for (int k = 0; k < N; k++) begin
         if (req[(b + k) % N]) return (b + k) % N;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ph = 0; own = 0; age = 0; base = 0; tf = 0;
      end else begin
         case (ph)
            0: if (m_req != 3'b000) begin
               own = pick(m_req, base);
`ifndef SBA_FIXED_PRIORITY_EN
               base = (own + 1) % N;
`endif
               ph = 1; age = 1;
            end
            1: if (!m_req[own]) ph = 2;
               else if (age == T) begin ph = 2; tf = 1; end
               else age++;
            2: begin ph = 3; age = 1; end
            default: if (slv_busy == 3'b000) ph = 0;
               else if (age == T) begin ph = 0; tf = 1; end
               else age++;
         endcase
      end
   end

   always @(negedge clk) begin
      chk("m_grant", int'(m_grant), (ph == 1) ? (1 << own) : 0);
      chk("grant_id", int'(grant_id), own);
      chk("bus_util", int'(bus_util), int'(ph == 0));
      chk("arbiter_cmd", int'(arbiter_cmd), int'(ph == 2));
      chk("timeout_flag", int'(timeout_flag), int'(tf));
      chk("state", int'(state), ph);
   end

   int cmd_pulses = 0;
   always @(posedge clk) if (arbiter_cmd) cmd_pulses++;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      cyc(2);
      rstn = 1'b1;
      cyc(1);
   endtask

   int order[4];
   int exp_order[4];
   int id;
   int waited;

   initial begin
      rstn = 1'b0;
      m_req = 3'b000;
      slv_busy = 3'b000;
      cyc(3);
      chk("rst_bus_util", int'(bus_util), 1);
      chk("rst_m_grant", int'(m_grant), 0);
      chk("rst_state", int'(state), 0);
      rstn = 1'b1;
      cyc(4);
      chk("idle_no_cmd", cmd_pulses, 0);
      chk("idle_bus_util", int'(bus_util), 1);

      // Single tenure by master 1 with a 4-cycle slave drain.
      m_req = 3'b010;
      cyc(1);
      chk("st_grant", int'(m_grant), 2);
      chk("st_gid", int'(grant_id), 1);
      cyc(9);
      chk("st_hold", int'(m_grant), 2);
      m_req = 3'b000;
      slv_busy = 3'b001;
      cyc(1);
      chk("st_cmd", int'(arbiter_cmd), 1);
      chk("st_rel_grant", int'(m_grant), 0);
      cyc(1);
      chk("st_cmd_off", int'(arbiter_cmd), 0);
      chk("st_drain", int'(state), 3);
      cyc(2);
      slv_busy = 3'b000;
      chk("st_busy_util", int'(bus_util), 0);
      cyc(1);
      chk("st_free", int'(bus_util), 1);

      // Round-robin order with all masters requesting.
      do_reset();
      m_req = 3'b111;
      for (int t = 0; t < 4; t++) begin
         waited = 0;
         while (m_grant == 3'b000 && waited < 20) begin
            cyc(1);
            waited++;
         end
         chk("rr_wait", int'(waited < 20), 1);
         id = int'(grant_id);
         order[t] = id;
         cyc(4);
         m_req[id] = 1'b0;
         cyc(1);
         m_req[id] = 1'b1;
      end
      m_req = 3'b000;
      cyc(6);
`ifdef SBA_FIXED_PRIORITY_EN
      exp_order = '{0, 0, 0, 0};
`else
      exp_order = '{0, 1, 2, 0};
`endif
      for (int t = 0; t < 4; t++) chk("rr_order", order[t], exp_order[t]);

      // Tenure watchdog.
      do_reset();
      m_req = 3'b001;
      cyc(16);
      chk("to_still_owned", int'(m_grant), 1);
      chk("to_flag_before", int'(timeout_flag), 0);
      cyc(1);
      chk("to_grant_off", int'(m_grant), 0);
      chk("to_cmd", int'(arbiter_cmd), 1);
      chk("to_flag", int'(timeout_flag), 1);
      m_req = 3'b000;
      cyc(8);
      chk("to_sticky", int'(timeout_flag), 1);

      // Drain watchdog with a stuck slave.
      do_reset();
      m_req = 3'b001;
      slv_busy = 3'b100;
      cyc(3);
      m_req = 3'b000;
      cyc(17);
      chk("dt_draining", int'(state), 3);
      chk("dt_flag_before", int'(timeout_flag), 0);
      cyc(1);
      chk("dt_idle", int'(state), 0);
      chk("dt_bus_util", int'(bus_util), 1);
      chk("dt_flag", int'(timeout_flag), 1);
      slv_busy = 3'b000;
      cyc(2);

      // Drop coincides with watchdog limit: release wins, no flag.
      do_reset();
      m_req = 3'b001;
      cyc(16);
      m_req = 3'b000;
      cyc(1);
      chk("sim_state", int'(state), 2);
      chk("sim_flag", int'(timeout_flag), 0);
      cyc(3);
      chk("sim_flag_later", int'(timeout_flag), 0);

      // Asynchronous reset in the middle of a tenure.
      m_req = 3'b010;
      cyc(3);
      chk("mid_owned", int'(m_grant), 2);
      #2;
      rstn = 1'b0;
      #1;
      chk("mid_grant", int'(m_grant), 0);
      chk("mid_gid", int'(grant_id), 0);
      chk("mid_bus_util", int'(bus_util), 1);
      chk("mid_state", int'(state), 0);
      m_req = 3'b000;
      cyc(2);
      rstn = 1'b1;
      cyc(3);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

endmodule
